mem_arbiter: RTL and testbench

//  Shares the single-port RAM between instruction fetch (I) and data load/store (D) for the datapath.

---
 rtl/cpu_types_pkg.sv | 19 +
 rtl/mem_arbiter.sv | 116 +++++++++++
 tb/tb_mem_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, RAM port state and memory arbiter state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the single-port RAM between instruction fetch and data load/store.
// Data wins by default; a starvation counter forces a fetch grant after STARVE_MAX losses.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       iREN,
  input  word_t      iaddr,
  output word_t      iload,
  output logic       iwait,
  input  logic       dREN,
  input  logic       dWEN,
  input  word_t      daddr,
  input  word_t      dstore,
  output word_t      dload,
  output logic       dwait,
  output logic       ramREN,
  output logic       ramWEN,
  output word_t      ramaddr,
  output word_t      ramstore,
  input  word_t      ramload,
  input  ramstate_t  ramstate,
  output logic       err,
  output arb_state_t state
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] tmo_cnt;

  logic dreq;
  logic grant_req;
  logic done_i;
  logic done_d;

  // Handshake: a requester holds its request until its wait goes low; the
  // cycle with request high and wait low is the one in which the access
  // completes and load data is valid. A side that is not requesting sees wait=0.
  assign dreq      = dREN | dWEN;
  assign grant_req = (state == IGNT) ? iREN : dreq;
  assign done_i    = (state == IGNT) && iREN && (ramstate == ACCESS);
  assign done_d    = (state == DGNT) && dreq && (ramstate == ACCESS);

  assign iwait = iREN & ~done_i;
  assign dwait = dreq & ~done_d;
  assign iload = ramload;
  assign dload = ramload;

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state)
      IGNT: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
      end
      DGNT: begin
        ramREN   = dREN & ~dWEN;
        ramWEN   = dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      starve_cnt <= '0;
      tmo_cnt    <= '0;
      err        <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (dreq && (starve_cnt < SW'(STARVE_MAX))) begin
            state <= DGNT;
            if (iREN) starve_cnt <= starve_cnt + 1'b1;
          end else if (iREN) begin
            state      <= IGNT;
            starve_cnt <= '0;
          end
        end
        IGNT, DGNT: begin
          if (!grant_req) begin
            state <= IDLE;
          end else if (ramstate == ACCESS) begin
            state <= IDLE;
          end else if (ramstate == ERROR) begin
            state <= IDLE;
            err   <= 1'b1;
          end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            state <= IDLE;
            err   <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      // A fetch that is no longer waiting has nothing to be starved of.
      if (!iREN) starve_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: grant order, latency, starvation guard, writes,
// timeout, RAM error, request drop and asynchronous reset.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic       CLK;
  logic       nRST;
  logic       iREN;
  word_t      iaddr;
  word_t      iload;
  logic       iwait;
  logic       dREN;
  logic       dWEN;
  word_t      daddr;
  word_t      dstore;
  word_t      dload;
  logic       dwait;
  logic       ramREN;
  logic       ramWEN;
  word_t      ramaddr;
  word_t      ramstore;
  word_t      ramload;
  ramstate_t  ramstate;
  logic       err;
  arb_state_t state;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.STARVE_MAX(4), .TIMEOUT(64)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err), .state(state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    int n;
    nRST = 1'b0; iREN = 1'b0; iaddr = '0; dREN = 1'b0; dWEN = 1'b0;
    daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
    tick(); tick();
    chk("rst_state", 32'(state), 32'(IDLE));
    chk("rst_ramREN", 32'(ramREN), 32'd0);
    chk("rst_ramWEN", 32'(ramWEN), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_waits", {30'd0, iwait, dwait}, 32'd0);
    nRST = 1'b1;
    tick();

    // instruction fetch alone: request -> IGNT -> ACCESS completes
    iREN = 1'b1; iaddr = 32'h40; ramstate = BUSY; settle();
    chk("i_req_wait", 32'(iwait), 32'd1);
    chk("i_idle_nostrobe", 32'(ramREN), 32'd0);
    tick();
    chk("i_state_ignt", 32'(state), 32'(IGNT));
    chk("i_ramREN", 32'(ramREN), 32'd1);
    chk("i_ramaddr", ramaddr, 32'h40);
    chk("i_busy_wait", 32'(iwait), 32'd1);
    ramstate = ACCESS; ramload = 32'h1234_5678; settle();
    chk("i_done_wait", 32'(iwait), 32'd0);
    chk("i_iload", iload, 32'h1234_5678);
    chk("i_dwait_idle", 32'(dwait), 32'd0);
    tick();
    chk("i_back_idle", 32'(state), 32'(IDLE));
    iREN = 1'b0; ramstate = BUSY; tick();

    // simultaneous I and D: D first, then I without a back-to-back grant
    iREN = 1'b1; dREN = 1'b1; daddr = 32'h200; tick();
    chk("sim_dgnt", 32'(state), 32'(DGNT));
    chk("sim_ramaddr_d", ramaddr, 32'h200);
    chk("sim_iwait", 32'(iwait), 32'd1);
    ramstate = ACCESS; ramload = 32'hCAFE_F00D; settle();
    chk("sim_dwait_done", 32'(dwait), 32'd0);
    chk("sim_dload", dload, 32'hCAFE_F00D);
    tick();
    dREN = 1'b0; ramstate = BUSY; settle();
    chk("sim_gap_idle", 32'(state), 32'(IDLE));
    chk("sim_gap_nostrobe", 32'(ramREN), 32'd0);
    tick();
    chk("sim_ignt", 32'(state), 32'(IGNT));
    chk("sim_ramaddr_i", ramaddr, 32'h40);
    ramstate = ACCESS; settle();
    chk("sim_i_done", 32'(iwait), 32'd0);
    tick();
    iREN = 1'b0; ramstate = BUSY; tick();

    // starvation: D always ready, I granted after four denied IDLE cycles
    iREN = 1'b1; dREN = 1'b1; daddr = 32'h300; ramstate = ACCESS; settle();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("stv_idle_%0d", k), 32'(state), 32'(IDLE));
      tick();
      chk($sformatf("stv_dgnt_%0d", k), 32'(state), 32'(DGNT));
      chk($sformatf("stv_ddone_%0d", k), 32'(dwait), 32'd0);
      tick();
    end
    chk("stv_last_idle", 32'(state), 32'(IDLE));
    tick();
    chk("stv_ignt", 32'(state), 32'(IGNT));
    chk("stv_i_done", 32'(iwait), 32'd0);
    chk("stv_d_waits", 32'(dwait), 32'd1);
    tick();
    iREN = 1'b0; dREN = 1'b0; ramstate = BUSY; tick();

    // data write
    dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEAD_BEEF; tick();
    chk("wr_dgnt", 32'(state), 32'(DGNT));
    chk("wr_ramWEN", 32'(ramWEN), 32'd1);
    chk("wr_ramREN", 32'(ramREN), 32'd0);
    chk("wr_ramstore", ramstore, 32'hDEAD_BEEF);
    chk("wr_ramaddr", ramaddr, 32'h100);
    chk("wr_busy_wait", 32'(dwait), 32'd1);
    ramstate = ACCESS; settle();
    chk("wr_done", 32'(dwait), 32'd0);
    tick();
    dWEN = 1'b0; dstore = '0; ramstate = BUSY; tick();

    // timeout: RAM stuck BUSY aborts after 64 granted cycles
    dREN = 1'b1; daddr = 32'h500; tick();
    n = 0;
    while (state == DGNT && n < 100) begin
      n++;
      if (err !== 1'b0) chk("tmo_early_err", 32'(err), 32'd0);
      tick();
    end
    chk("tmo_cycles", 32'(n), 32'd64);
    chk("tmo_state", 32'(state), 32'(IDLE));
    chk("tmo_err", 32'(err), 32'd1);
    dREN = 1'b0; tick();
    chk("tmo_err_pulse", 32'(err), 32'd0);

    // RAM error during a fetch grant
    iREN = 1'b1; iaddr = 32'h44; tick();
    chk("er_ignt", 32'(state), 32'(IGNT));
    ramstate = ERROR; settle();
    chk("er_iwait", 32'(iwait), 32'd1);
    tick();
    chk("er_state", 32'(state), 32'(IDLE));
    chk("er_err", 32'(err), 32'd1);
    iREN = 1'b0; ramstate = BUSY; tick();
    chk("er_err_clear", 32'(err), 32'd0);

    // requester drops while granted: abort without error
    dREN = 1'b1; tick();
    chk("drop_dgnt", 32'(state), 32'(DGNT));
    dREN = 1'b0; settle();
    chk("drop_dwait", 32'(dwait), 32'd0);
    tick();
    chk("drop_idle", 32'(state), 32'(IDLE));
    chk("drop_noerr", 32'(err), 32'd0);

    // asynchronous reset in the middle of a write grant
    dWEN = 1'b1; dstore = 32'h0BAD_F00D; tick();
    chk("rstw_ramWEN", 32'(ramWEN), 32'd1);
    #2 nRST = 1'b0; #1;
    chk("rstw_ramWEN_low", 32'(ramWEN), 32'd0);
    chk("rstw_ramREN_low", 32'(ramREN), 32'd0);
    chk("rstw_state", 32'(state), 32'(IDLE));
    chk("rstw_err", 32'(err), 32'd0);
    dWEN = 1'b0; tick();
    nRST = 1'b1; tick();
    chk("post_rst_idle", 32'(state), 32'(IDLE));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
